// File: rtl/ramb_pkg.sv
// ramb_pkg: shared parameter defaults and FSM state encoding for the RAM burst master
package ramb_pkg;
   localparam int RAMB_DEPTH = 10;
   localparam int RAMB_AW = 6;
   localparam int RAMB_DW = 16;
   localparam logic [2:0] S_IDLE = 3'd0, S_WRITE = 3'd1, S_READ = 3'd2, S_DRAIN = 3'd3, S_ERR = 3'd4;
endpackage

// File: rtl/ramb_rd_buf.sv
// ramb_rd_buf: one-entry read output register that holds its word until consumed
//   load  : capture din and mark valid (wins over clr)
//   clr   : drop valid once the last word has been taken
//   valid / data : registered read-data stream outputs
module ramb_rd_buf #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          clr,
   input  logic [DW-1:0] din,
   output logic          valid,
   output logic [DW-1:0] data
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end else if (clr) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/ramb_master.sv
// ramb_master: burst read/write master in front of a RAM with combinational read data
//   cmd_*  : burst command (rd, start addr, length), accepted only while idle
//   wr_*   : write-data stream consumed during a write burst
//   rd_*   : read-data stream produced during a read burst
//   mem_*  : RAM port (write enable, address, write data, read data)
//   busy / err : burst in progress / one-cycle illegal-command pulse
module ramb_master
   import ramb_pkg::*;
#(
   parameter int DEPTH = RAMB_DEPTH,
   parameter int AW    = RAMB_AW,
   parameter int DW    = RAMB_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_rd,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_di,
   input  logic [DW-1:0] mem_do,
   output logic          busy,
   output logic          err
);
   logic [2:0]    st;
   logic [AW-1:0] ptr, cnt;
   logic          illegal, in_wr, in_rd, last, rd_load;
   // range check done one bit wider so addr+len cannot wrap into a legal value
   assign illegal   = cmd_len == '0 || {1'b0, cmd_addr} + {1'b0, cmd_len} > (AW+1)'(DEPTH);
   assign in_wr     = st == S_WRITE;
   assign in_rd     = st == S_READ;
   assign last      = cnt == AW'(1);
   assign rd_load   = in_rd && (!rd_valid || rd_ready);
   assign cmd_ready = st == S_IDLE;
   assign busy      = st != S_IDLE;
   assign err       = st == S_ERR;
   assign wr_ready  = in_wr;
   assign mem_we    = in_wr && wr_valid;
   assign mem_a     = (in_wr || in_rd) ? ptr : '0;
   assign mem_di    = in_wr ? wr_data : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= S_IDLE;
         ptr <= '0;
         cnt <= '0;
      end else begin
         case (st)
            S_IDLE: if (cmd_valid) begin
               st  <= illegal ? S_ERR : cmd_rd ? S_READ : S_WRITE;
               ptr <= cmd_addr;
               cnt <= cmd_len;
            end
            S_WRITE: if (wr_valid) begin
               ptr <= ptr + AW'(1);
               cnt <= cnt - AW'(1);
               st  <= last ? S_IDLE : S_WRITE;
            end
            S_READ: if (rd_load) begin
               ptr <= ptr + AW'(1);
               cnt <= cnt - AW'(1);
               st  <= last ? S_DRAIN : S_READ;
            end
            S_DRAIN: st <= rd_ready ? S_IDLE : S_DRAIN;
            default: st <= S_IDLE;
         endcase
      end
   end
   ramb_rd_buf #(.DW(DW)) u_rd_buf (
      .clk  (clk),
      .rst_n(rst_n),
      .load (rd_load),
      .clr  (st == S_DRAIN && rd_ready),
      .din  (mem_do),
      .valid(rd_valid),
      .data (rd_data)
   );
endmodule

// File: tb/tb_ramb_master.sv
// tb_ramb_master: randomized self-checking bench against a word-array memory model
module tb_ramb_master;
   localparam int DEPTH = 10, AW = 6, DW = 16;
   logic          clk = 0, rst_n = 0;
   logic          cmd_valid = 0, cmd_ready, cmd_rd = 0;
   logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
   logic          wr_valid = 0, wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid, rd_ready = 0;
   logic [DW-1:0] rd_data;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_di, mem_do;
   logic          busy, err;
   logic [DW-1:0] ram [0:63];
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   logic          load_ram = 0;
   int            n_cmp = 0, n_bad = 0, we_cnt = 0;

   ramb_master #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
      end else if (mem_we) begin
         ram[mem_a] <= mem_di;
         we_cnt <= we_cnt + 1;
      end
   end
   assign mem_do = ram[mem_a];

   task automatic test_reset;
      rst_n = 0;
      load_ram = 1;
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, busy, err, rd_valid, wr_ready, mem_we} !== 6'b100000) begin
         n_bad++;
         $display("FAIL reset_ctl: {cmd_ready,busy,err,rd_valid,wr_ready,mem_we}=%b want 100000",
                  {cmd_ready, busy, err, rd_valid, wr_ready, mem_we});
      end
      n_cmp++;
      if (rd_data !== '0 || mem_a !== '0 || mem_di !== '0) begin
         n_bad++;
         $display("FAIL reset_data: rd_data=%h mem_a=%h mem_di=%h want 0", rd_data, mem_a, mem_di);
      end
      load_ram = 0;
      rst_n = 1;
   endtask

   task automatic run_write(input int addr, input int len, input bit gaps, input bit fixed);
      int i = 0, cyc = 0;
      bit v;
      logic [DW-1:0] d;
      @(negedge clk);
      cmd_valid = 1; cmd_rd = 0; cmd_addr = AW'(addr); cmd_len = AW'(len);
      @(negedge clk);
      cmd_valid = 0;
      while (i < len && cyc < 4 * len + 20) begin
         cyc++;
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         d = fixed ? DW'(16'h1111 * (i + 1)) : DW'($urandom);
         wr_valid = v; wr_data = d;
         #1;
         n_cmp++;
         if (wr_ready !== 1'b1 || mem_we !== v || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_hs: wr_ready=%b mem_we=%b busy=%b want 1/%b/1", wr_ready, mem_we, busy, v);
         end
         if (v) begin
            n_cmp++;
            if (mem_a !== AW'(addr + i) || mem_di !== d) begin
               n_bad++;
               $display("FAIL wr_word: mem_a=%0d mem_di=%h want %0d/%h", mem_a, mem_di, addr + i, d);
            end
            ref_mem[addr + i] = d;
            i++;
         end
         @(negedge clk);
      end
      wr_valid = 0;
      n_cmp++;
      if (i != len || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL wr_end: words=%0d busy=%b cmd_ready=%b want %0d/0/1", i, busy, cmd_ready, len);
      end
   endtask

   // mode 0: rd_ready always high, 1: random rd_ready, 2: rd_ready low for 3 cycles after first word
   task automatic run_read(input int addr, input int len, input int mode);
      int k = 0, cyc = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_rd = 1; cmd_addr = AW'(addr); cmd_len = AW'(len);
      rd_ready = (mode == 0);
      @(negedge clk);
      cmd_valid = 0;
      n_cmp++;
      if (rd_valid !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_start: rd_valid=%b busy=%b want 0/1", rd_valid, busy);
      end
      while (k < len && cyc < 8 * len + 20) begin
         @(negedge clk);
         cyc++;
         rd_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (cyc > 3);
         if (mode != 1) begin
            n_cmp++;
            if (rd_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL rd_valid: cycle %0d rd_valid=%b want 1", cyc, rd_valid);
            end
         end
         if (rd_valid) begin
            n_cmp++;
            if (rd_data !== ref_mem[addr + k]) begin
               n_bad++;
               $display("FAIL rd_data: word %0d rd_data=%h want %h", k, rd_data, ref_mem[addr + k]);
            end
            if (rd_ready) k++;
         end
      end
      @(negedge clk);
      rd_ready = 0;
      n_cmp++;
      if (k != len || busy !== 1'b0 || rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_end: words=%0d busy=%b rd_valid=%b want %0d/0/0", k, busy, rd_valid, len);
      end
   endtask

   task automatic test_illegal(input int addr, input int len);
      int w0 = we_cnt;
      @(negedge clk);
      cmd_valid = 1; cmd_rd = 0; cmd_addr = AW'(addr); cmd_len = AW'(len); wr_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || cmd_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL err_pulse: addr=%0d len=%0d err=%b busy=%b mem_we=%b want 1/1/0", addr, len, err, busy, mem_we);
      end
      @(negedge clk);
      wr_valid = 0;
      n_cmp++;
      if (err !== 1'b0 || cmd_ready !== 1'b1 || we_cnt != w0) begin
         n_bad++;
         $display("FAIL err_end: err=%b cmd_ready=%b writes=%0d want 0/1/0", err, cmd_ready, we_cnt - w0);
      end
   endtask

   task automatic test_reset_mid;
      int addr = $urandom_range(0, DEPTH - 4);
      logic [DW-1:0] d1 = DW'($urandom), d2 = DW'($urandom);
      @(negedge clk);
      cmd_valid = 1; cmd_rd = 0; cmd_addr = AW'(addr); cmd_len = AW'(4);
      @(negedge clk);
      cmd_valid = 0; wr_valid = 1; wr_data = d1;
      @(negedge clk);
      wr_data = d2;
      ref_mem[addr] = d1;
      #1;
      rst_n = 0;
      #1;
      n_cmp++;
      if ({cmd_ready, busy, err, rd_valid, wr_ready, mem_we} !== 6'b100000 || mem_a !== '0 || mem_di !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: ctl=%b mem_a=%h mem_di=%h want 100000/0/0",
                  {cmd_ready, busy, err, rd_valid, wr_ready, mem_we}, mem_a, mem_di);
      end
      @(negedge clk);
      wr_valid = 0;
      rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (ram[i] !== ref_mem[i]) begin
            n_bad++;
            $display("FAIL reset_ram: ram[%0d]=%h want %h", i, ram[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_cmd_hold;
      logic [DW-1:0] d0 = DW'($urandom), d1 = DW'($urandom);
      @(negedge clk);
      cmd_valid = 1; cmd_rd = 0; cmd_addr = '0; cmd_len = AW'(2); wr_valid = 1; wr_data = d0;
      @(negedge clk);
      cmd_rd = 1;
      n_cmp++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || mem_a !== AW'(0)) begin
         n_bad++;
         $display("FAIL hold_w0: cmd_ready=%b busy=%b mem_a=%0d want 0/1/0", cmd_ready, busy, mem_a);
      end
      @(negedge clk);
      wr_data = d1;
      n_cmp++;
      if (cmd_ready !== 1'b0 || mem_a !== AW'(1)) begin
         n_bad++;
         $display("FAIL hold_w1: cmd_ready=%b mem_a=%0d want 0/1", cmd_ready, mem_a);
      end
      ref_mem[0] = d0; ref_mem[1] = d1;
      @(negedge clk);
      wr_valid = 0; rd_ready = 1;
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_idle: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
      end
      @(negedge clk);
      cmd_valid = 0;
      n_cmp++;
      if (busy !== 1'b1 || rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_rd_acc: busy=%b rd_valid=%b want 1/0", busy, rd_valid);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rd_valid !== 1'b1 || rd_data !== ref_mem[i]) begin
            n_bad++;
            $display("FAIL hold_rd%0d: rd_valid=%b rd_data=%h want 1/%h", i, rd_valid, rd_data, ref_mem[i]);
         end
      end
      @(negedge clk);
      rd_ready = 0;
      n_cmp++;
      if (busy !== 1'b0 || rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_end: busy=%b rd_valid=%b want 0/0", busy, rd_valid);
      end
   endtask

   task automatic test_random;
      int addr, len;
      repeat (30) begin
         addr = $urandom_range(0, 63);
         len = $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0 && (len == 0 || addr + len > DEPTH)) test_illegal(addr, len);
         else begin
            addr = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(1, DEPTH - addr);
            if ($urandom_range(0, 1) == 1) run_write(addr, len, 1, 0);
            else run_read(addr, len, 1);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
      test_reset;
      run_write(2, 3, 0, 1);
      run_read(2, 3, 0);
      run_read(2, 2, 2);
      test_illegal(8, 3);
      test_illegal(0, 0);
      test_illegal(0, 11);
      test_illegal(60, 10);
      test_illegal(63, 63);
      run_write(7, 3, 0, 0);
      run_read(7, 3, 0);
      run_write(0, DEPTH, 1, 0);
      run_read(0, DEPTH, 0);
      test_reset_mid;
      test_cmd_hold;
      test_random;
      run_read(0, DEPTH, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ramb_master.md
RAMB_MASTER -- requirements
Module: ramb_master

Interface
REQ-001 SHALL have parameter DEPTH, default 10, meaning number of addressable words in the attached RAM (legal addresses 0..DEPTH-1).
REQ-002 SHALL have parameter AW, default 6, meaning address width.
REQ-003 SHALL have parameter DW, default 16, meaning data word width.
REQ-004 SHALL have clk  input  1  single clock; all state changes on posedge clk.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid  input  1  command offered.
REQ-007 SHALL have cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have cmd_rd  input  1  1 = read burst, 0 = write burst.
REQ-009 SHALL have cmd_addr  input  AW  burst start address.
REQ-010 SHALL have cmd_len  input  AW  burst length in words.
REQ-011 SHALL have wr_valid / wr_ready / wr_data  input / output / input  1 / 1 / DW  write-data stream.
REQ-012 SHALL have rd_valid / rd_ready / rd_data  output / input / output  1 / 1 / DW  read-data stream.
REQ-013 SHALL have mem_we / mem_a / mem_di  output  1 / AW / DW  RAM write enable, address, write data.
REQ-014 SHALL have mem_do  input  DW  RAM combinational read data for mem_a.
REQ-015 SHALL have busy / err  output  1 / 1  burst in progress / one-cycle illegal-command pulse.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DRAIN, ERR.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-018 SHALL, on acceptance, latch addr pointer=cmd_addr and remaining count=cmd_len.
REQ-019 SHALL treat cmd_len==0, or cmd_addr+cmd_len>DEPTH (computed at AW+1 bits, no wrap), as illegal: go to ERR, assert err for exactly one cycle, return to IDLE, issue no RAM access.
REQ-020 SHALL, in WRITE, drive wr_ready=1, mem_we=wr_valid, mem_a=pointer, mem_di=wr_data (combinational from state).
REQ-021 SHALL, on each wr_valid&&wr_ready, increment pointer and decrement count; after the last word go to IDLE next cycle; wr_valid gaps stall with mem_we=0.
REQ-022 SHALL drive mem_we=0 in every state other than WRITE; wr_ready=0 outside WRITE.
REQ-023 SHALL, in READ, drive mem_a=pointer and load rd_data<=mem_do, set rd_valid=1, advance pointer, decrement count whenever the output register is empty or rd_ready=1.
REQ-024 SHALL hold rd_data and rd_valid stable while rd_valid && !rd_ready.
REQ-025 SHALL present the first rd_valid one cycle after read-command acceptance; sustain one word/cycle with rd_ready held high.
REQ-026 SHALL, after the last word is loaded, go to DRAIN; leave DRAIN to IDLE on rd_ready, clearing rd_valid.
REQ-027 SHALL ignore cmd_valid while busy (no queuing).
REQ-028 SHALL deliver read words in ascending address order cmd_addr..cmd_addr+cmd_len-1.

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE, cmd_ready=1, busy=0, err=0, rd_valid=0, rd_data=0, mem_we=0, mem_a=0, mem_di=0, wr_ready=0.
REQ-030 SHALL abandon any burst on mid-operation reset; partial writes stay in RAM; no further RAM write occurs.

Structure
REQ-031 SHALL take DEPTH, AW, DW defaults and the state enumeration from shared package ramb_pkg.
REQ-032 SHALL place the one-entry read output register with hold logic in sub-module ramb_rd_buf.

Verification
REQ-033 SHALL cover write addr=2 len=3 data 0x1111,0x2222,0x3333 with wr_valid high -> mem_we high three consecutive cycles at mem_a 2,3,4, then IDLE.
REQ-034 SHALL cover read addr=2 len=3 with rd_ready high -> rd_valid cycles 1..3 after accept, rd_data 0x1111,0x2222,0x3333.
REQ-035 SHALL cover read len=2 with rd_ready low 3 cycles after first word -> rd_data holds first word, no data lost, second word follows.
REQ-036 SHALL cover cmd addr=8 len=3 (DEPTH=10) and len=0 -> err one-cycle pulse each, mem_we never high, back in IDLE.
REQ-037 SHALL cover rst_n low mid-write after word 1 of 4 -> outputs at reset values same cycle, only address of word 1 modified.
REQ-038 SHALL cover cmd_valid held high during burst -> cmd_ready=0, second command accepted only after return to IDLE.
